// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave bus between two masters (m0 = CPU).
// A grant covers one transfer; a watchdog completes transfers the slaves never acknowledge.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             m0_valid,
    input  logic             m0_instr,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic             m0_ready,
    input  logic             m1_valid,
    input  logic             m1_instr,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wstrb,
    output logic             m1_ready,
    output logic [31:0]      m_rdata,
    output logic             s_valid,
    output logic             s_instr,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    input  logic             s_ready,
    input  logic [31:0]      s_rdata,
    output logic [1:0]       grant,
    output logic             timeout_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_BUSY    = 2'd1;
    localparam logic [1:0]  S_TOUT    = 2'd2;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [15:0]      wdog_q, wdog_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic owner_valid;
    logic pick;

    assign owner_valid = owner_q ? m1_valid : m0_valid;
    // On a tie the master that did not own the previous transfer wins.
    assign pick        = (m0_valid && m1_valid) ? ~last_q : m1_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = S_BUSY;
                    owner_d = pick;
                    last_d  = pick;
                    wdog_d  = '0;
                end
            end
            S_BUSY: begin
                // Abort and acknowledge both take priority over the watchdog.
                if (!owner_valid || s_ready) begin
                    state_d = S_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_TOUT;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            S_TOUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m_rdata     = '0;
        grant       = 2'b00;
        timeout_err = 1'b0;
        if (state_q != S_IDLE) begin
            grant   = owner_q ? 2'b10 : 2'b01;
            s_instr = owner_q ? m1_instr : m0_instr;
            s_addr  = owner_q ? m1_addr  : m0_addr;
            s_wdata = owner_q ? m1_wdata : m0_wdata;
            s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
        end
        if (state_q == S_BUSY) begin
            s_valid  = owner_valid;
            m_rdata  = s_rdata;
            m0_ready = s_ready & owner_valid & ~owner_q;
            m1_ready = s_ready & owner_valid & owner_q;
        end else if (state_q == S_TOUT) begin
            m0_ready    = ~owner_q;
            m1_ready    = owner_q;
            m_rdata     = ERR_DATA;
            timeout_err = 1'b1;
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected completions,
// a monitor pops and compares them whenever a master sees ready.
module tb_mem_bus_arbiter;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 2;

    logic             clk;
    logic             resetn;
    logic             mv [2];
    logic             mi [2];
    logic [31:0]      ma [2];
    logic [31:0]      mw [2];
    logic [3:0]       ms [2];
    logic             m0_ready, m1_ready;
    logic [31:0]      m_rdata;
    logic             s_valid, s_instr;
    logic [31:0]      s_addr, s_wdata;
    logic [3:0]       s_wstrb;
    logic             s_ready = 1'b0;
    logic [31:0]      s_rdata = '0;
    logic [1:0]       grant;
    logic             timeout_err;
    logic [CNT_W-1:0] err_count;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
        .m0_ready(m0_ready),
        .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
        .m1_ready(m1_ready),
        .m_rdata(m_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int               m;
        logic [31:0]      rdata;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   ready_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] rd, input logic err, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.m = m; e.rdata = rd; e.err = err; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Inputs change at posedge+2; the slave model reacts at posedge+3; checks run at negedge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: acknowledges on the slave_lat-th BUSY cycle (0 = never).
    int          slave_lat   = 1;
    int          scnt        = 0;
    int          busy_len    = 0;
    logic [31:0] slave_rdata = '0;

    always @(posedge clk) begin
        #3;
        if (s_valid) begin
            scnt++;
            busy_len = scnt;
            s_ready  = (slave_lat != 0) && (scnt == slave_lat);
        end else begin
            scnt    = 0;
            s_ready = 1'b0;
        end
        s_rdata = slave_rdata;
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (resetn && (m0_ready || m1_ready)) begin
            ready_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: m0_ready=%0b m1_ready=%0b with nothing pending", m0_ready, m1_ready);
            end else begin
                mon_e = exp_q.pop_front();
                check("ready_owner", 32'({m1_ready, m0_ready}), (mon_e.m == 0) ? 32'd1 : 32'd2);
                check("m_rdata", m_rdata, mon_e.rdata);
                check("timeout_err", 32'(timeout_err), 32'(mon_e.err));
                check("err_count", 32'(err_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic do_xfer(input int m, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        bit done;
        done  = 1'b0;
        mv[m] = 1'b1; ma[m] = addr; mw[m] = wdata; ms[m] = strb; mi[m] = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_wait: master %0d saw no ready within 64 cycles", m);
        end
        @(posedge clk);
        #2;
        mv[m] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ok;
        resetn = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mi[m] = 1'b0; ma[m] = '0; mw[m] = '0; ms[m] = '0;
        end
        #3 resetn = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Single master, zero-wait read.
        slave_lat   = 1;
        slave_rdata = 32'h1234_5678;
        push_exp(0, 32'h1234_5678, 1'b0, 2'd0);
        mv[0] = 1'b1; ma[0] = 32'h0000_0100; mw[0] = '0; ms[0] = 4'h0;
        @(negedge clk);
        check("zw_grant_n", 32'(grant), 32'd0);
        @(negedge clk);
        check("zw_grant_n1", 32'(grant), 32'd1);
        check("zw_s_valid", 32'(s_valid), 32'd1);
        check("zw_s_addr", s_addr, 32'h0000_0100);
        check("zw_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        mv[0] = 1'b0;
        @(negedge clk);
        check("zw_idle_n2", 32'(grant), 32'd0);
        check("zw_ready_drop", 32'(m0_ready), 32'd0);

        // Reset again so the contention tie is resolved from reset.
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;

        // Contention: both masters write continuously; owners must alternate m0, m1, ...
        slave_lat   = 1;
        slave_rdata = 32'h5A5A_0000;
        for (int i = 0; i < 8; i++) push_exp(i % 2, 32'h5A5A_0000, 1'b0, 2'd0);
        ready_cyc.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_xfer(0, 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
            end
            begin
                for (int i = 0; i < 4; i++) do_xfer(1, 32'h400 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
            end
        join
        check("cont_count", 32'(ready_cyc.size()), 32'd8);
        ok = 1'b1;
        for (int i = 1; i < ready_cyc.size(); i++) begin
            if (ready_cyc[i] - ready_cyc[i-1] != 2) ok = 1'b0;
        end
        check("cont_two_cycle_spacing", 32'(ok), 32'd1);

        // Timeout: m1 read of an unmapped address.
        tick();
        slave_lat = 0;
        push_exp(1, 32'hDEADBEEF, 1'b1, 2'd1);
        do_xfer(1, 32'hF000_0000, 32'h0, 4'h0);
        check("tout_busy_cycles", 32'(busy_len), 32'(TIMEOUT));

        // Race: ack arrives on the last watchdog cycle; slave wins.
        slave_lat   = 4;
        slave_rdata = 32'hCAFE_0001;
        push_exp(0, 32'hCAFE_0001, 1'b0, 2'd1);
        do_xfer(0, 32'h0000_0300, 32'h0, 4'h0);
        check("race_busy_cycles", 32'(busy_len), 32'd4);

        // Saturation: four more timeouts take the 2-bit counter 2, 3, 3, 3.
        slave_lat = 0;
        for (int i = 0; i < 4; i++) begin
            push_exp(i % 2, 32'hDEADBEEF, 1'b1, (i == 0) ? 2'd2 : 2'd3);
            do_xfer(i % 2, 32'hF000_0010, 32'h0, 4'h0);
        end

        // Asynchronous reset in the middle of a BUSY cycle.
        mv[1] = 1'b1; ma[1] = 32'hF000_0020; ms[1] = 4'h0;
        @(posedge clk);
        #4;
        check("ar_pre_s_valid", 32'(s_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("ar_s_valid", 32'(s_valid), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_m1_ready", 32'(m1_ready), 32'd0);
        check("ar_err_count", 32'(err_count), 32'd0);
        mv[1] = 1'b0;
        tick();
        resetn = 1'b1;

        // After reset the CPU wins the first tie.
        slave_lat   = 1;
        slave_rdata = 32'h0BAD_F00D;
        push_exp(0, 32'h0BAD_F00D, 1'b0, 2'd0);
        push_exp(1, 32'h0BAD_F00D, 1'b0, 2'd0);
        fork
            do_xfer(0, 32'h0000_0500, 32'h0, 4'h0);
            do_xfer(1, 32'h0000_0600, 32'h0, 4'h0);
        join

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the native valid/ready memory bus. It sits between the picorv32 CPU and a second bus master (DMA or debug loader) on one side, and the shared slave bus (address decoder, memory, gpio, prng, uartTx, timer) on the other. Grants are round-robin, and a grant is held for exactly one transfer. A watchdog completes any transfer the slaves never acknowledge, so an unmapped address cannot hang either master.

## Interface
Parameters:
- TIMEOUT, 255, max BUSY cycles without s_ready before forced completion (1..65535)
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transfer
- CNT_W, 8, width of the saturating error counter

Ports (m = master index 0/1, m0 = CPU):
- clk  in  1  system clock; all state changes on its rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_valid, m1_valid  in  1  master request
- m0_instr, m1_instr  in  1  instruction-fetch qualifier
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 means read
- m0_ready, m1_ready  out  1  transfer complete, one cycle per transfer
- m_rdata  out  32  read data, common to both masters, valid when the granted mX_ready is high
- s_valid, s_instr, s_addr, s_wdata, s_wstrb  out  1/1/32/32/4  muxed slave request
- s_ready  in  1  slave acknowledge
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  one-cycle pulse on forced completion
- err_count  out  CNT_W  saturating count of timeouts

## Operation
- States: IDLE, BUSY, TOUT. The state, owner and last-owner registers are clocked.
- IDLE:
  - If only one mX_valid is high, grant it.
  - If both are high, grant the master that is not last-owner. Last-owner resets to 1, so the CPU wins the first tie.
  - On a grant, go to BUSY: latch owner, set last-owner = owner, clear the watchdog.
- BUSY:
  - s_* = owner's request fields (combinational mux on the owner register). s_valid = owner's valid.
  - mX_ready[owner] = s_ready. m_rdata = s_rdata.
  - On s_ready: return to IDLE.
  - Otherwise, when the watchdog equals TIMEOUT-1: go to TOUT.
  - Otherwise: increment the watchdog.
- TOUT (exactly one cycle):
  - s_valid = 0, mX_ready[owner] = 1, m_rdata = ERR_DATA, timeout_err = 1.
  - err_count increments, saturating at all-ones.
  - Return to IDLE. s_ready in TOUT is ignored.
- Abort: if the owner drops valid while in BUSY, s_valid falls in the same cycle. The arbiter returns to IDLE with no ready and no error.
- Non-owner: mX_ready = 0 at all times. Its request is held pending and never lost.
- In IDLE: s_valid = 0, s_addr/s_wdata = 0, s_wstrb = 0, grant = 00, both mX_ready = 0.

## Timing
- Reset (asynchronous, immediate, independent of clk):
  - State IDLE, grant 00, s_valid 0, all s_* 0, m0_ready/m1_ready 0, m_rdata 0, timeout_err 0, err_count 0, last-owner 1.
  - A transfer in flight is dropped silently.
- Grant latency: mX_valid rising in cycle n gives grant and s_valid in cycle n+1.
- Zero-wait slave: s_ready in cycle n+1 gives mX_ready in cycle n+1 and IDLE in cycle n+2. Minimum is 2 cycles per transfer.
- Turnaround: there is always ≥1 IDLE cycle between transfers, so picorv32's post-ready valid drop is never seen as a new request.
- Back-to-back contention: transfers alternate owners (A, idle, B, idle, A...). A master waits at most one transfer plus 2 cycles.
- Timeout: TIMEOUT BUSY cycles without s_ready, then TOUT in cycle n+TIMEOUT+1.
- s_ready and the watchdog reaching TIMEOUT-1 in the same cycle: s_ready wins, normal completion, no error.
- err_count at all-ones plus another timeout: the pulse still fires and the count holds.

## Test plan
- Single master, zero-wait: m0 reads 0x0000_0100 and the slave returns 0x1234_5678 with s_ready on the first BUSY cycle. Expect grant=01 at n+1, m0_ready high for exactly one cycle with m_rdata 0x1234_5678, IDLE at n+2.
- Contention: m0 and m1 request writes together from reset. Expect m0 served first, then m1, with one IDLE cycle between. With both held continuously, grants alternate 01/10 for 8 transfers.
- Timeout: TIMEOUT=4, m1 reads 0xF000_0000 and s_ready is never asserted. Expect s_valid high for 4 cycles, then a TOUT cycle with m1_ready=1, m_rdata=0xDEADBEEF, timeout_err=1, err_count=1.
- Race: TIMEOUT=4, s_ready in the 4th BUSY cycle. Expect normal completion with slave data, timeout_err=0, err_count unchanged.
- Async reset: assert resetn low mid-BUSY, between clock edges. Expect s_valid, grant and ready at 0 immediately. After release, m0 is granted first on a tie.
- Saturation: CNT_W=2, force 5 timeouts. Expect err_count 1, 2, 3, 3, 3 and five timeout_err pulses.
